// File: rtl/timer_tc.sv
// TC0 memory-mapped 32-bit down-counting timer with one-shot/periodic modes.
// Register reads are combinational; IRQ is the masked expiry flag.
module timer_tc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_preset;
  logic [DATA_W-1:0]   r_count;
  logic [DATA_W-1:0]   w_count_nxt;
  logic                r_irq_flag;

  logic                w_wr_ctrl;
  logic                w_wr_preset;
  logic                w_flag_set;
  logic                w_flag_clr_fsm;
  logic                w_en_clr;
  logic                w_periodic;
  logic                w_unused_addr;

  assign w_wr_ctrl     = WE && (Addr[3:2] == REG_CTRL);
  assign w_wr_preset   = WE && (Addr[3:2] == REG_PRESET);
  assign w_periodic    = (r_ctrl[2:1] == MODE_PERIODIC);
  assign w_unused_addr = ^Addr[31:4];

  // Next-state and count sequencing
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_flag_set     = 1'b0;
    w_flag_clr_fsm = 1'b0;
    w_en_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ctrl[0]) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_ctrl[0]) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > DATA_W'(1)) begin
          w_count_nxt = r_count - DATA_W'(1);
        end else begin
          // A count of 0 (PRESET = 0) expires exactly like a count of 1
          w_count_nxt = '0;
          w_flag_set  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (w_periodic) w_flag_clr_fsm = 1'b1;
        else            w_en_clr       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registers: CPU write beats the one-shot EN clear; expiry beats the write-clear of irq_flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ctrl     <= '0;
      r_preset   <= '0;
      r_count    <= '0;
      r_irq_flag <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_wr_ctrl)     r_ctrl    <= Din[CTRL_W-1:0];
      else if (w_en_clr) r_ctrl[0] <= 1'b0;
      if (w_wr_preset) r_preset <= Din;
      if (w_flag_set)
        r_irq_flag <= 1'b1;
      else if (w_wr_ctrl || w_wr_preset || w_flag_clr_fsm)
        r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      REG_CTRL:   Dout = {{(DATA_W-CTRL_W){1'b0}}, r_ctrl};
      REG_PRESET: Dout = r_preset;
      REG_COUNT:  Dout = r_count;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = r_ctrl[3] & r_irq_flag;

endmodule

// File: tb/tb_timer_tc.sv
// Self-checking bench for timer_tc: step-indexed reference model compared every
// cycle, plus directed literal expectations on the key timing points.
module tb_timer_tc;

  localparam logic [31:2] BASE = 30'h1FC0;

  logic        clk;
  logic        rst;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  timer_tc dut (
    .clk  (clk),
    .rst  (rst),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_k counts edges since the timer left idle (0 = idle,
  // 1 = loading, 2..P+1 = counting, P+2 = expired), P = max(PRESET,1).
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  longint      m_k;
  longint      m_p;

  always @(posedge clk) begin
    logic wr_c, wr_p, set_f, clr_f, en_clr;
    if (rst) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_k = 0; m_p = 1;
    end else begin
      wr_c = WE && (Addr[3:2] == 2'd0);
      wr_p = WE && (Addr[3:2] == 2'd1);
      set_f = 1'b0; clr_f = 1'b0; en_clr = 1'b0;
      if (m_k == 0) begin
        if (m_ctrl[0]) m_k = 1;
      end else if (m_k == 1) begin
        m_count = m_preset;
        m_p = (m_preset == 32'd0) ? 1 : longint'(m_preset);
        m_k = 2;
      end else if (m_k <= m_p + 1) begin
        if (!m_ctrl[0]) m_k = 0;
        else if (m_k < m_p + 1) begin
          m_count = 32'(m_p - (m_k - 1));
          m_k = m_k + 1;
        end else begin
          m_count = '0;
          set_f = 1'b1;
          m_k = m_p + 2;
        end
      end else begin
        if (m_ctrl[2:1] == 2'b01) clr_f = 1'b1;
        else en_clr = 1'b1;
        m_k = 0;
      end
      if (wr_c) m_ctrl = Din[3:0];
      else if (en_clr) m_ctrl[0] = 1'b0;
      if (wr_p) m_preset = Din;
      if (set_f) m_flag = 1'b1;
      else if (wr_c || wr_p || clr_f) m_flag = 1'b0;
    end
  end

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dout", Dout, exp_dout(Addr[3:2]));
      check("model_irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_addr(input logic [1:0] a);
    Addr = BASE;
    Addr[3:2] = a;
    #1;
  endtask

  // One write strobe on the next posedge; returns 2 ns after that edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = BASE;
    Addr[3:2] = a;
    Din = d;
    WE = 1'b1;
    @(posedge clk);
    #2;
    WE = 1'b0;
    Din = '0;
    Addr = BASE;
    Addr[3:2] = 2'd2;
  endtask

  task automatic lit_irq(input string name, input logic exp);
    check(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    rst = 1'b1; WE = 1'b0; Din = '0;
    Addr = BASE; Addr[3:2] = 2'd2;
    tick(2);
    chk_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      set_addr(2'(a));
      check("reset_dout", Dout, 32'd0);
    end
    lit_irq("reset_irq", 1'b0);
    rst = 1'b0;
    set_addr(2'd2);

    // One-shot, PRESET = 5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2); check("os_count_e2", Dout, 32'd5);
    tick(4); check("os_count_e6", Dout, 32'd1); lit_irq("os_irq_e6", 1'b0);
    tick(1); lit_irq("os_irq_e7", 1'b1);
    tick(1); set_addr(2'd0); check("os_ctrl_e8", Dout, 32'h8);
    set_addr(2'd2); lit_irq("os_irq_e8", 1'b1);
    wr(2'd0, 32'h8); lit_irq("os_irq_cleared", 1'b0);

    // Periodic, PRESET = 3: pulses at E5, E11, E17
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      lit_irq("per_irq", (k == 5) || (k == 11) || (k == 17));
      if (k == 8 || k == 14) check("per_reload", Dout, 32'd3);
    end
    wr(2'd0, 32'h8);

    // Pause at 60, then restart reloads from PRESET
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    tick(41); check("pause_pre", Dout, 32'd61);
    wr(2'd0, 32'h8);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("pause_hold", Dout, 32'd60);
      lit_irq("pause_irq", 1'b0);
    end
    wr(2'd0, 32'h9);
    tick(2); check("restart_reload", Dout, 32'd100);
    wr(2'd0, 32'h8);

    // Masked expiry, then CTRL write clears the flag
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    tick(4); lit_irq("mask_irq_e4", 1'b0);
    tick(1); set_addr(2'd0); check("mask_ctrl_e5", Dout, 32'h0);
    set_addr(2'd2);
    wr(2'd0, 32'h8); lit_irq("mask_irq_after_im", 1'b0);

    // IM set by a write on the expiry edge: flag set wins, IRQ immediate
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    tick(3);
    wr(2'd0, 32'h9); lit_irq("im_late_irq", 1'b1);
    tick(1); lit_irq("im_late_hold", 1'b1);
    set_addr(2'd0); check("im_late_ctrl", Dout, 32'h8);
    set_addr(2'd2);
    wr(2'd0, 32'h8); lit_irq("im_late_clear", 1'b0);

    // Periodic PRESET = 2 with a PRESET write on the expiry edge
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    tick(3);
    wr(2'd1, 32'd7); lit_irq("pcol_irq", 1'b1);
    tick(1); lit_irq("pcol_pulse_end", 1'b0);
    tick(2); check("pcol_new_preset", Dout, 32'd7);
    wr(2'd0, 32'h0);
    tick(1); check("stop_freeze", Dout, 32'd6);

    // Writes to COUNT and the unmapped slot are ignored
    wr(2'd2, 32'hFFFF); check("count_ro", Dout, 32'd6);
    wr(2'd3, 32'hFFFF);
    set_addr(2'd3); check("unmapped_rd", Dout, 32'd0);
    set_addr(2'd2); check("count_ro2", Dout, 32'd6);

    // PRESET = 0 expires at E3 like PRESET = 1
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    tick(2); check("p0_count_e2", Dout, 32'd0); lit_irq("p0_irq_e2", 1'b0);
    tick(1); lit_irq("p0_irq_e3", 1'b1);
    wr(2'd0, 32'h8);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick(2); check("p1_count_e2", Dout, 32'd1); lit_irq("p1_irq_e2", 1'b0);
    tick(1); lit_irq("p1_irq_e3", 1'b1);
    wr(2'd0, 32'h8);

    // CPU write to CTRL on the one-shot INT edge keeps EN set
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick(5); lit_irq("icol_irq_e5", 1'b1);
    wr(2'd0, 32'h9); lit_irq("icol_irq_cleared", 1'b0);
    set_addr(2'd0); check("icol_ctrl", Dout, 32'h9);
    set_addr(2'd2);
    tick(2); check("icol_reload", Dout, 32'd3);
    wr(2'd0, 32'h0);

    // Reset mid-count
    wr(2'd1, 32'd50);
    wr(2'd0, 32'h9);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_count", Dout, 32'd0); lit_irq("mrst_irq", 1'b0);
    set_addr(2'd1); check("mrst_preset", Dout, 32'd0);
    set_addr(2'd0); check("mrst_ctrl", Dout, 32'd0);
    set_addr(2'd2);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_tc.md
# timer_tc

Memory-mapped 32-bit down-counting timer on the TC0 window (0x7f00–0x7f0b) behind the data-side bridge. It consumes the bridge's word address, write enable and store data, and returns read data combinationally so the bridge can register it on the same edge. It raises a maskable interrupt request toward CP0 when the count expires, in one-shot or periodic mode.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- Addr  in  30 (bits [31:2])  word address from bridge; only Addr[3:2] decoded.
- WE  in  1  register write strobe, already gated by bridge address decode.
- Din  in  32  write data (full word).
- Dout  out  32  read data, combinational from Addr and current registers.
- IRQ  out  1  interrupt request = CTRL[3] & irq_flag.

## Operation
- Register map by Addr[3:2]:
  - 0: CTRL. Bit [0] is EN, bits [2:1] are MODE, bit [3] is IM. Bits [31:4] read 0.
  - 1: PRESET (32-bit, R/W).
  - 2: COUNT (32-bit, read-only; writes ignored).
  - 3: unmapped; reads 0, writes ignored.
- MODE encoding:
  - 00: one-shot.
  - 01: periodic.
  - 1x: reserved, behaves as one-shot.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: if CTRL[0], go to LOAD; otherwise hold. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !CTRL[0]: go to IDLE, COUNT frozen.
    - Else if COUNT > 1: COUNT <= COUNT-1.
    - Else (COUNT is 1 or 0): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, one-shot: CTRL[0] <= 0; go to IDLE; irq_flag stays set.
  - INT, periodic: irq_flag <= 0; go to IDLE (auto-restarts because EN is still 1).
- irq_flag is cleared by any CPU write to CTRL or PRESET, in any state.
- Write/FSM collision on CTRL[0] (INT one-shot clear vs. CPU write in the same cycle): the CPU write wins.
- irq_flag collision (CPU write clears, CNT expiry sets in the same cycle): the set wins.
- A PRESET write during CNT does not alter COUNT; it takes effect at the next LOAD.
- Clearing EN mid-count freezes COUNT at its current value. Re-enabling goes IDLE→LOAD and reloads from PRESET; there is no resume.
- PRESET = 0 behaves identically to PRESET = 1.
- Arithmetic is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- Reset: CTRL, PRESET, COUNT and irq_flag are 0, state is IDLE, IRQ = 0. Dout = 0 for every Addr after reset.
- Reset asserted mid-count returns everything to the reset values on that edge; no IRQ is emitted.
- Register writes take effect at the posedge on which WE is high. Dout reflects the new value in the following cycle.
- Dout is purely combinational. There is zero-cycle read latency, so the bridge samples it on the same edge as the access.
- Latency from the edge that writes CTRL.EN=1 (call it E0), with PRESET = N ≥ 1:
  - E1: LOAD.
  - E2: COUNT = N.
  - E(N+2): COUNT = 0, state INT, IRQ rises (if IM = 1).
- Periodic mode: IRQ is a 1-cycle pulse every N+3 cycles.
- One-shot mode: IRQ stays high until a write to CTRL or PRESET. CTRL[0] reads 0 from E(N+3).
- IM = 0 masks IRQ only. irq_flag still sets, and IRQ asserts immediately if IM is later set.

## Test plan
- Reset check: with rst held 2 cycles, read all 4 addresses → Dout = 0 for each, IRQ = 0.
- One-shot: PRESET = 5, then CTRL = 0x9 at edge E0 → COUNT reads 5 at E2 and 1 at E6; IRQ rises at E7; CTRL reads 0x8 from E8. Writing CTRL = 0x8 drops IRQ the next cycle.
- Periodic: PRESET = 3, CTRL = 0xB → IRQ pulses for exactly 1 cycle, first at E5, then every 6 cycles (E11, E17), with COUNT reloading to 3 each period.
- Pause/restart: PRESET = 100, enable, then at COUNT = 60 write CTRL = 0x8 → COUNT stays at 60 for 10 cycles and IRQ = 0. Write CTRL = 0x9 → COUNT reloads to 100 two cycles later.
- Masking and collisions:
  - PRESET = 2, CTRL = 0x1 → no IRQ at expiry. Writing CTRL = 0x8 then clears irq_flag, so IRQ stays 0.
  - Periodic PRESET = 2 with a PRESET write landing on the expiry edge → IRQ still asserts.
- Illegal accesses: write 0xFFFF to Addr[3:2] = 2 or 3 → COUNT unchanged, Dout at Addr[3:2] = 3 stays 0. PRESET = 0 with EN set → IRQ at E3, same as PRESET = 1.
